// File: rtl/reg_access_pkg.sv
// Shared types and constants for the register-bank access arbiter.
package reg_access_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StWaitRd = 2'd2,
        StResp   = 2'd3
    } state_e;

    localparam logic OWNER_I2C  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    localparam logic [7:0] RO_BASE_DEFAULT = 8'hF0;

    // Wide enough to hold the largest legal read latency (4).
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. The pointer names the side favoured on a tie
// and is moved away from the side just served when upd_i is pulsed.
module rr_arb2
    import reg_access_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic upd_i,
    input  logic upd_side_i,
    output logic gnt_o,
    output logic sel_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = ~upd_side_i;
        end
        gnt_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            sel_o = ptr_q;
        end else begin
            sel_o = req1_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= OWNER_I2C;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates the I2C slave and the local host onto a single-port register bank,
// sequencing each access and rejecting writes to the read-only upper region.
module reg_access_arbiter
    import reg_access_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 8,
    parameter int unsigned          DATA_W     = 8,
    parameter int unsigned          RD_LATENCY = 1,
    parameter logic [ADDR_W-1:0]    RO_BASE    = ADDR_W'(RO_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i2c_req,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_ack,
    output logic              i2c_err,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              host_err,

    output logic              bank_en,
    output logic              bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata,

    output logic              owner
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   i2c_rdata_q, i2c_rdata_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;

    logic arb_gnt, arb_sel, arb_upd;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_i     (i2c_req),
        .req1_i     (host_req),
        .upd_i      (arb_upd),
        .upd_side_i (owner_q),
        .gnt_o      (arb_gnt),
        .sel_o      (arb_sel)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        i2c_rdata_d  = i2c_rdata_q;
        host_rdata_d = host_rdata_q;
        bank_en      = 1'b0;
        bank_we      = 1'b0;
        i2c_ack      = 1'b0;
        i2c_err      = 1'b0;
        host_ack     = 1'b0;
        host_err     = 1'b0;
        arb_upd      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_gnt) begin
                    owner_d = arb_sel;
                    if (arb_sel == OWNER_HOST) begin
                        we_d    = host_we;
                        addr_d  = host_addr;
                        wdata_d = host_wdata;
                    end else begin
                        we_d    = i2c_we;
                        addr_d  = i2c_addr;
                        wdata_d = i2c_wdata;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (we_q && (addr_q >= RO_BASE)) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (we_q) begin
                    bank_en = 1'b1;
                    bank_we = 1'b1;
                    state_d = StResp;
                end else begin
                    bank_en = 1'b1;
                    cnt_d   = CNT_W'(RD_LATENCY);
                    state_d = StWaitRd;
                end
            end
            StWaitRd: begin
                // A count of 1 marks the cycle in which bank_rdata is valid.
                if (cnt_q == CNT_W'(1)) begin
                    if (owner_q == OWNER_HOST) begin
                        host_rdata_d = bank_rdata;
                    end else begin
                        i2c_rdata_d = bank_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (owner_q == OWNER_HOST) begin
                    host_ack = 1'b1;
                    host_err = err_q;
                end else begin
                    i2c_ack = 1'b1;
                    i2c_err = err_q;
                end
                arb_upd = 1'b1;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= OWNER_I2C;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            i2c_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            i2c_rdata_q  <= i2c_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bank_addr  = addr_q;
    assign bank_wdata = wdata_q;
    assign i2c_rdata  = i2c_rdata_q;
    assign host_rdata = host_rdata_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: one instance at read latency 1 backed by a
// memory model, one at latency 4 backed by an address-derived read pattern.
module tb_reg_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       i2c_req, i2c_we, host_req, host_we;
    logic [7:0] i2c_addr, i2c_wdata, host_addr, host_wdata;

    logic [7:0] i2c_rdata1, host_rdata1, bank_addr1, bank_wdata1, bank_rdata1;
    logic       i2c_ack1, i2c_err1, host_ack1, host_err1, bank_en1, bank_we1, owner1;
    logic [7:0] i2c_rdata4, host_rdata4, bank_addr4, bank_wdata4, bank_rdata4;
    logic       i2c_ack4, i2c_err4, host_ack4, host_err4, bank_en4, bank_we4, owner4;

    reg_access_arbiter u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_rdata(i2c_rdata1), .i2c_ack(i2c_ack1), .i2c_err(i2c_err1),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata1), .host_ack(host_ack1), .host_err(host_err1),
        .bank_en(bank_en1), .bank_we(bank_we1), .bank_addr(bank_addr1),
        .bank_wdata(bank_wdata1), .bank_rdata(bank_rdata1), .owner(owner1)
    );

    reg_access_arbiter #(.RD_LATENCY(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_rdata(i2c_rdata4), .i2c_ack(i2c_ack4), .i2c_err(i2c_err4),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata4), .host_ack(host_ack4), .host_err(host_err4),
        .bank_en(bank_en4), .bank_we(bank_we4), .bank_addr(bank_addr4),
        .bank_wdata(bank_wdata4), .bank_rdata(bank_rdata4), .owner(owner4)
    );

    // Bank models: memory reloads to addr^0x3C during reset; latency-4 bank returns addr^0x5A.
    logic [7:0] mem [256];
    logic [7:0] pipe1;
    logic [7:0] pipe4 [4];

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (bank_en1 && bank_we1) begin
            mem[bank_addr1] <= bank_wdata1;
        end
        pipe1 <= (bank_en1 && !bank_we1) ? mem[bank_addr1] : 8'hEE;
        pipe4[0] <= (bank_en4 && !bank_we4) ? (bank_addr4 ^ 8'h5A) : 8'hEE;
        for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
    end
    assign bank_rdata1 = pipe1;
    assign bank_rdata4 = pipe4[3];

    logic       sel4;
    logic       s_iack, s_ierr, s_hack, s_herr, s_ben, s_bwe, s_own;
    logic [7:0] s_ird, s_hrd, s_baddr, s_bwd;

    always_comb begin
        s_iack = sel4 ? i2c_ack4 : i2c_ack1;
        s_ierr = sel4 ? i2c_err4 : i2c_err1;
        s_hack = sel4 ? host_ack4 : host_ack1;
        s_herr = sel4 ? host_err4 : host_err1;
        s_ben = sel4 ? bank_en4 : bank_en1;
        s_bwe = sel4 ? bank_we4 : bank_we1;
        s_own = sel4 ? owner4 : owner1;
        s_ird = sel4 ? i2c_rdata4 : i2c_rdata1;
        s_hrd = sel4 ? host_rdata4 : host_rdata1;
        s_baddr = sel4 ? bank_addr4 : bank_addr1;
        s_bwd = sel4 ? bank_wdata4 : bank_wdata1;
    end

    typedef struct {
        bit         side;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_ird, exp_hrd;

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, want %02h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit side, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (side) begin
            host_req = req; host_we = we; host_addr = addr; host_wdata = wdata;
        end else begin
            i2c_req = req; i2c_we = we; i2c_addr = addr; i2c_wdata = wdata;
        end
    endtask

    task automatic chk_zero(input string tag);
        chkb({tag, ".bank_en"}, s_ben, 1'b0);
        chkb({tag, ".bank_we"}, s_bwe, 1'b0);
        chkb({tag, ".i2c_ack"}, s_iack | s_ierr, 1'b0);
        chkb({tag, ".host_ack"}, s_hack | s_herr, 1'b0);
        chkb({tag, ".owner"}, s_own, 1'b0);
        chk8({tag, ".i2c_rdata"}, s_ird, 8'h00);
        chk8({tag, ".host_rdata"}, s_hrd, 8'h00);
        chk8({tag, ".bank_addr"}, s_baddr, 8'h00);
        chk8({tag, ".bank_wdata"}, s_bwd, 8'h00);
    endtask

    // Leaves the bench at a negedge with the DUT in IDLE.
    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        exp_ird = 8'h00;
        exp_hrd = 8'h00;
    endtask

    // Cycle 0 is the negedge-to-posedge window in which req is raised with the DUT idle.
    task automatic do_txn(input vec_t v, input string tag);
        int ack_c = -1;
        int en_cnt = 0;
        bit oth = 1'b0;
        logic ben1 = 1'bx, bwe1 = 1'bx, own1 = 1'bx, err_v = 1'bx;
        logic [7:0] baddr1 = 8'hxx, bwd1 = 8'hxx, rd_v = 8'hxx;
        drive(v.side, 1'b1, v.we, v.addr, v.wdata);
        for (int c = 1; c <= 12 && ack_c < 0; c++) begin
            @(negedge clk);
            if (s_ben) en_cnt++;
            if (c == 1) begin
                ben1 = s_ben; bwe1 = s_bwe; baddr1 = s_baddr; bwd1 = s_bwd; own1 = s_own;
                drive(v.side, 1'b1, v.we, v.addr ^ 8'hFF, v.wdata ^ 8'hFF);
            end
            if (v.side ? (s_iack | s_ierr) : (s_hack | s_herr)) oth = 1'b1;
            if (v.side ? s_hack : s_iack) begin
                ack_c = c;
                err_v = v.side ? s_herr : s_ierr;
                rd_v = v.side ? s_hrd : s_ird;
                drive(v.side, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        if (!v.we) begin
            if (v.side) exp_hrd = v.exp_rd;
            else exp_ird = v.exp_rd;
        end
        chk_int({tag, ".ack_cycle"}, ack_c, v.exp_lat);
        chkb({tag, ".err"}, err_v, v.exp_err);
        chkb({tag, ".owner"}, own1, v.side);
        chkb({tag, ".other_ack"}, oth, 1'b0);
        chkb({tag, ".bank_en_c1"}, ben1, !v.exp_err);
        chk_int({tag, ".bank_en_pulses"}, en_cnt, v.exp_err ? 0 : 1);
        if (!v.exp_err) begin
            chkb({tag, ".bank_we"}, bwe1, v.we);
            chk8({tag, ".bank_addr"}, baddr1, v.addr);
            if (v.we) chk8({tag, ".bank_wdata"}, bwd1, v.wdata);
        end
        chk8({tag, ".rdata"}, rd_v, v.side ? exp_hrd : exp_ird);
        @(negedge clk);
    endtask

    task automatic reset_mid(input int at_c, input vec_t v, input string tag);
        bit seen = 1'b0;
        drive(v.side, 1'b1, 1'b0, v.addr, 8'h00);
        for (int c = 1; c <= at_c; c++) begin
            @(negedge clk);
            if (s_iack | s_hack) seen = 1'b1;
        end
        reset_n = 1'b0;
        drive(v.side, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chkb({tag, ".no_ack_before"}, seen | s_iack | s_hack, 1'b0);
        chk_zero(tag);
        reset_n = 1'b1;
        exp_ird = 8'h00;
        exp_hrd = 8'h00;
        @(negedge clk);
        chkb({tag, ".no_ack_after"}, s_iack | s_hack, 1'b0);
        do_txn(v, {tag, ".retry"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        int ni, nh, k, last;
        bit side;

        //        side  we  addr   wdata  err  rdata  lat
        vecs[0]  = '{1'b0, 1'b1, 8'h12, 8'hA5, 1'b0, 8'h00, 2};
        vecs[1]  = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'hA5, 3};
        vecs[2]  = '{1'b0, 1'b1, 8'hF3, 8'h77, 1'b1, 8'h00, 2};
        vecs[3]  = '{1'b0, 1'b0, 8'hF3, 8'h00, 1'b0, 8'hCF, 3};
        vecs[4]  = '{1'b1, 1'b1, 8'h40, 8'h5A, 1'b0, 8'h00, 2};
        vecs[5]  = '{1'b0, 1'b0, 8'h40, 8'h00, 1'b0, 8'h5A, 3};
        vecs[6]  = '{1'b1, 1'b1, 8'hEF, 8'h11, 1'b0, 8'h00, 2};
        vecs[7]  = '{1'b1, 1'b1, 8'hF0, 8'h22, 1'b1, 8'h00, 2};
        vecs[8]  = '{1'b1, 1'b0, 8'hF0, 8'h00, 1'b0, 8'hCC, 3};
        vecs[9]  = '{1'b0, 1'b0, 8'hEF, 8'h00, 1'b0, 8'h11, 3};
        vecs[10] = '{1'b0, 1'b1, 8'hFF, 8'h99, 1'b1, 8'h00, 2};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h3C, 3};

        sel4 = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Both sides request together from reset, each holding req for three reads.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'h40, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'hEF, 8'h00);
        ni = 0; nh = 0; k = 0; last = 0;
        for (int c = 1; c <= 60 && (ni < 3 || nh < 3); c++) begin
            @(negedge clk);
            if (s_iack || s_hack) begin
                side = s_hack;
                chkb("rr.single_ack", s_iack & s_hack, 1'b0);
                chkb("rr.order", side, (k % 2) == 1);
                chkb("rr.owner", s_own, side);
                chk_int("rr.gap", c - last, (k == 0) ? 3 : 4);
                chk8("rr.rdata", side ? s_hrd : s_ird, side ? 8'hD3 : 8'h7C);
                last = c;
                k++;
                if (side) begin
                    nh++;
                    if (nh == 3) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
                end else begin
                    ni++;
                    if (ni == 3) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
                end
            end
        end
        chk_int("rr.i2c_count", ni, 3);
        chk_int("rr.host_count", nh, 3);
        @(negedge clk);

        reset_mid(2, '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h2E, 3}, "rst_l1");

        sel4 = 1'b1;
        do_reset();
        do_txn('{1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 8'h69, 6}, "l4_read");
        do_txn('{1'b0, 1'b1, 8'h20, 8'h44, 1'b0, 8'h00, 2}, "l4_write");
        do_txn('{1'b0, 1'b1, 8'hF5, 8'h44, 1'b1, 8'h00, 2}, "l4_prot");
        reset_mid(3, '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h48, 6}, "rst_l4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
